// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide scheduler: E-stage ops, core ops,
// FSM states and the latency-counter width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        CO_MULT  = 2'd0,
        CO_MULTU = 2'd1,
        CO_DIV   = 2'd2,
        CO_DIVU  = 2'd3
    } core_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter must hold the larger of the two latencies.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int mx;
        mx = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return (mx < 2) ? 1 : $clog2(mx + 1);
    endfunction

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W          = cnt_width(MUL_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/mdu_sched_if.sv
// E-stage request / core-control / HI-LO write bundle between the pipeline
// and the MDU scheduler.
interface mdu_sched_if;
    logic       e_valid;
    logic [2:0] e_op;
    logic       e_div_zero;
    logic       d_uses_md;
    logic       flush;

    logic       core_start;
    logic [1:0] core_op;
    logic       hi_we;
    logic       lo_we;
    logic       hilo_sel;
    logic       busy;
    logic       stall_d;
    logic       proto_err;

    modport master (
        output e_valid, e_op, e_div_zero, d_uses_md, flush,
        input  core_start, core_op, hi_we, lo_we, hilo_sel, busy, stall_d, proto_err
    );

    modport slave (
        input  e_valid, e_op, e_div_zero, d_uses_md, flush,
        output core_start, core_op, hi_we, lo_we, hilo_sel, busy, stall_d, proto_err
    );
endinterface

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter that times an in-flight multiply/divide.
module mdu_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign last = (cnt == W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: issues ops to the arithmetic core, times them,
// commits HI/LO, gates MTHI/MTLO and raises the D-stage stall.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  md
);

    localparam int W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    state_e         state, state_nxt;
    logic           zero_kill;
    logic           proto_err_q;
    logic           e_live;
    logic           e_is_div;
    logic           e_is_md;
    logic           load;
    logic [W-1:0]   load_val;
    logic [W-1:0]   cnt;
    logic           last;
    logic           zero;

    // Reset also masks E-stage actions so nothing commits in the reset cycle.
    assign e_live   = md.e_valid & ~md.flush & ~reset;
    assign e_is_div = (md.e_op == MD_DIV) || (md.e_op == MD_DIVU);
    assign e_is_md  = (md.e_op >= MD_MULT) && (md.e_op <= MD_MTLO);

    mdu_lat_counter #(.W(W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (state == ST_RUN),
        .cnt      (cnt),
        .last     (last),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            zero_kill   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load)
                zero_kill <= md.e_div_zero & e_is_div;
            if (state == ST_RUN && e_live && e_is_md)
                proto_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        load_val      = '0;
        md.core_start = 1'b0;
        md.core_op    = 2'd0;
        md.hi_we      = 1'b0;
        md.lo_we      = 1'b0;
        md.hilo_sel   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (e_live) begin
                    case (md_op_e'(md.e_op))
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            md.core_start = 1'b1;
                            md.core_op    = md.e_op[1:0] - 2'd1;
                            load          = 1'b1;
                            load_val      = e_is_div ? W'(DIV_CYCLES) : W'(MUL_CYCLES);
                            state_nxt     = ST_RUN;
                        end
                        MD_MTHI: begin
                            md.hi_we    = 1'b1;
                            md.hilo_sel = 1'b1;
                        end
                        MD_MTLO: begin
                            md.lo_we    = 1'b1;
                            md.hilo_sel = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // An expired counter outside the commit cycle just drops back to idle.
                if (last) begin
                    md.hi_we  = ~zero_kill & ~reset;
                    md.lo_we  = ~zero_kill & ~reset;
                    state_nxt = ST_IDLE;
                end else if (zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign md.busy      = (state == ST_RUN);
    assign md.stall_d   = md.d_uses_md & (md.busy | md.core_start);
    assign md.proto_err = proto_err_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Scenario bench for mdu_sched: per-cycle expected outputs are queued as
// stimulus is applied and compared against the DUT on the falling edge.
module tb_mdu_sched;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_sched_if bus ();
    mdu_sched_if bus1 ();

    mdu_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    mdu_sched #(.MUL_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .md    (bus1)
    );

    typedef struct packed {
        logic       cs;
        logic [1:0] op;
        logic       hw;
        logic       lw;
        logic       sel;
        logic       busy;
        logic       stall;
        logic       perr;
    } out_t;

    out_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // core_op is only meaningful alongside core_start, so it is masked otherwise.
    function automatic out_t ev(input bit cs, input logic [1:0] op, input bit hw, input bit lw,
                                input bit sel, input bit busy, input bit stall, input bit perr);
        out_t r;
        r.cs = cs; r.op = cs ? op : 2'd0; r.hw = hw; r.lw = lw;
        r.sel = sel; r.busy = busy; r.stall = stall; r.perr = perr;
        return r;
    endfunction

    function automatic out_t obs0();
        out_t r;
        r.cs = bus.core_start; r.op = bus.core_start ? bus.core_op : 2'd0;
        r.hw = bus.hi_we; r.lw = bus.lo_we; r.sel = bus.hilo_sel;
        r.busy = bus.busy; r.stall = bus.stall_d; r.perr = bus.proto_err;
        return r;
    endfunction

    function automatic out_t obs1();
        out_t r;
        r.cs = bus1.core_start; r.op = bus1.core_start ? bus1.core_op : 2'd0;
        r.hw = bus1.hi_we; r.lw = bus1.lo_we; r.sel = bus1.hilo_sel;
        r.busy = bus1.busy; r.stall = bus1.stall_d; r.perr = bus1.proto_err;
        return r;
    endfunction

    task automatic drive(input bit v, input logic [2:0] op, input bit dz, input bit dmd, input bit fl);
        bus.e_valid = v; bus.e_op = op; bus.e_div_zero = dz; bus.d_uses_md = dmd; bus.flush = fl;
    endtask

    task automatic drive1(input bit v, input logic [2:0] op, input bit dz, input bit dmd, input bit fl);
        bus1.e_valid = v; bus1.e_op = op; bus1.e_div_zero = dz; bus1.d_uses_md = dmd; bus1.flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t o, e;
        // Reset held with a MULT in E: nothing may start.
        reset = 1'b1;
        drive(1, MD_MULT, 0, 1, 0);
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL reset_hold: got %b want %b", o, e); end
        tick();
        reset = 1'b0;
        drive(0, MD_NONE, 0, 0, 0);
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL reset_after: got %b want %b", o, e); end
        tick();
    endtask

    task automatic test_mult();
        out_t o, e;
        for (int c = 0; c <= 7; c++) begin
            drive(c == 0, (c == 0) ? MD_MULT : MD_NONE, 0, 1, 0);
            exp_q.push_back(ev(c == 0, CO_MULT, c == 5, c == 5, 0, c >= 1 && c <= 5, c <= 5, 0));
            @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL mult c%0d: got %b want %b", c, o, e); end
            tick();
        end
    endtask

    task automatic test_divu_zero();
        out_t o, e;
        for (int c = 0; c <= 12; c++) begin
            drive(c == 0, (c == 0) ? MD_DIVU : MD_NONE, c == 0, c >= 8, 0);
            exp_q.push_back(ev(c == 0, CO_DIVU, 0, 0, 0, c >= 1 && c <= 10, c >= 8 && c <= 10, 0));
            @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL divu_zero c%0d: got %b want %b", c, o, e); end
            tick();
        end
    endtask

    task automatic test_mt();
        out_t o, e;
        for (int c = 0; c <= 3; c++) begin
            case (c)
                0: drive(1, MD_MTHI, 0, 1, 0);
                1: drive(1, MD_MTLO, 0, 1, 0);
                2: drive(1, MD_MTHI, 0, 1, 1);
                default: drive(1, MD_RSVD, 0, 1, 0);
            endcase
            exp_q.push_back(ev(0, 0, c == 0, c == 1, c <= 1, 0, 0, 0));
            @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL mt c%0d: got %b want %b", c, o, e); end
            tick();
        end
    endtask

    task automatic test_flush();
        out_t o, e;
        for (int c = 0; c <= 8; c++) begin
            case (c)
                0: drive(1, MD_DIV, 0, 0, 1);
                2: drive(1, MD_MULT, 0, 0, 0);
                5: drive(0, MD_NONE, 0, 0, 1);
                default: drive(0, MD_NONE, 0, 0, 0);
            endcase
            exp_q.push_back(ev(c == 2, CO_MULT, c == 7, c == 7, 0, c >= 3 && c <= 7, 0, 0));
            @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL flush c%0d: got %b want %b", c, o, e); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_t o, e;
        for (int c = 0; c <= 17; c++) begin
            case (c)
                0: drive(1, MD_MULTU, 0, 1, 0);
                6: drive(1, MD_DIV, 0, 1, 0);
                default: drive(0, MD_NONE, 0, 1, 0);
            endcase
            exp_q.push_back(ev(c == 0 || c == 6, (c == 0) ? CO_MULTU : CO_DIV,
                               c == 5 || c == 16, c == 5 || c == 16, 0,
                               (c >= 1 && c <= 5) || (c >= 7 && c <= 16), c <= 16, 0));
            @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL b2b c%0d: got %b want %b", c, o, e); end
            tick();
        end
    endtask

    task automatic test_n1();
        out_t o, e;
        for (int c = 0; c <= 4; c++) begin
            case (c)
                0: drive1(1, MD_MULT, 0, 1, 0);
                2: drive1(1, MD_DIVU, 0, 1, 0);
                default: drive1(0, MD_NONE, 0, 1, 0);
            endcase
            exp_q.push_back(ev(c == 0 || c == 2, (c == 0) ? CO_MULT : CO_DIVU,
                               c == 1 || c == 3, c == 1 || c == 3, 0, c == 1 || c == 3, c <= 3, 0));
            @(negedge clk); o = obs1(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL n1 c%0d: got %b want %b", c, o, e); end
            tick();
        end
        drive1(0, MD_NONE, 0, 0, 0);
    endtask

    task automatic test_proto_err();
        out_t o, e;
        for (int c = 0; c <= 8; c++) begin
            case (c)
                0: drive(1, MD_MULT, 0, 0, 0);
                2: drive(1, MD_DIV, 0, 0, 0);
                default: drive(0, MD_NONE, 0, 0, 0);
            endcase
            exp_q.push_back(ev(c == 0, CO_MULT, c == 5, c == 5, 0, c >= 1 && c <= 5, 0, c >= 3));
            @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL proto_err c%0d: got %b want %b", c, o, e); end
            tick();
        end
    endtask

    // Runs with proto_err still set from the previous scenario so the reset clears it.
    task automatic test_reset_mid_run();
        out_t o, e;
        for (int c = 0; c <= 11; c++) begin
            reset = (c == 4);
            drive(c == 0, (c == 0) ? MD_DIV : MD_NONE, 0, 0, 0);
            exp_q.push_back(ev(c == 0, CO_DIV, 0, 0, 0, c >= 1 && c <= 4, 0, c <= 4));
            @(negedge clk); o = obs0(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL reset_mid c%0d: got %b want %b", c, o, e); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, MD_NONE, 0, 0, 0);
        drive1(0, MD_NONE, 0, 0, 0);
        repeat (2) tick();
        test_reset();
        test_mult();
        test_divu_zero();
        test_mt();
        test_flush();
        test_back_to_back();
        test_n1();
        test_proto_err();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Scheduler/controller for the multiply-divide datapath in the 5-stage MIPS pipeline. Sits between the E stage and the multi-cycle arithmetic core and owns all sequencing:
- issues start and op to the core;
- counts per-op latency and commits the result to HI/LO;
- gates MTHI/MTLO writes;
- generates the D-stage stall for MDU-class instructions;
- cancels issue on interrupt/flush.

The core only computes. It latches operands on `core_start` and holds its result stable until the next start.

## Interface
- `MUL_CYCLES`, default 5: cycles from MULT/MULTU start to commit (≥1).
- `DIV_CYCLES`, default 10: cycles from DIV/DIVU start to commit (≥1).
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `e_valid` in 1: E-stage instruction valid.
- `e_op` in 3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is reserved and treated as NONE.
- `e_div_zero` in 1: E-stage divisor operand is zero.
- `d_uses_md` in 1: D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `flush` in 1: interrupt/exception this cycle; kills the E-stage instruction.
- `core_start` out 1: start pulse to the core (combinational).
- `core_op` out 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; valid while `core_start`.
- `hi_we` out 1, `lo_we` out 1: HI/LO write enables.
- `hilo_sel` out 1: 0 = HI/LO from core result, 1 = from E-stage rs operand (MT*).
- `busy` out 1: operation in flight.
- `stall_d` out 1: stall request to the hazard unit.
- `proto_err` out 1: sticky; set when an MDU op arrives in E while `busy`.

## Operation
- States are IDLE and RUN, with a 4-bit down-counter `cnt`.
- Issue, in IDLE only: `issue = e_valid & ~flush & (e_op in 1..4)`.
  - `core_start = issue`; `core_op = e_op - 1`.
  - Load `cnt` with MUL_CYCLES or DIV_CYCLES.
  - Latch `zero_kill = e_div_zero & (e_op in 3..4)`.
  - Go to RUN.
- MT*, in IDLE only: `e_valid & ~flush & e_op==5` → `hi_we=1, hilo_sel=1`. `e_op==6` → `lo_we=1, hilo_sel=1`. Same cycle, no state change.
- RUN behaviour:
  - Each cycle, `cnt` decrements.
  - When `cnt==1`: `hi_we=lo_we=~zero_kill`, `hilo_sel=0`, next state IDLE.
  - `flush` in RUN has no effect; an issued op always completes, per MIPS semantics.
- Divide-by-zero runs the full DIV_CYCLES, then commits nothing. HI/LO are unchanged.
- `busy = (state==RUN)`.
- `stall_d = d_uses_md & (busy | core_start)`.
- MDU op in E while `busy` is illegal: ignored, no write, `proto_err` set until reset.
- Reset values: state IDLE, `cnt=0`, `zero_kill=0`, `proto_err=0`. All outputs are 0 on the cycle after reset.
- Reset mid-RUN: abort to IDLE next edge; no commit that cycle or later.

## Timing
- Start at cycle T (`core_start=1`).
- `busy=1` for cycles T+1 .. T+N, where N = MUL_CYCLES or DIV_CYCLES.
- Commit write enables are asserted in cycle T+N; HI/LO are updated at the end of T+N.
- `busy=0` from T+N+1. A new start is possible in T+N+1.
- `stall_d` is asserted from T through T+N when `d_uses_md`.
  - It releases in T+N+1, so a following MFHI/MFLO reads committed HI/LO.
- MT* write has zero latency: enable asserted in the E cycle, register updated at its end.
- `flush` and an issue-eligible op in the same cycle: no start, no write, state stays IDLE.
- N=1: commit in T+1; `busy` high exactly one cycle.

## Structure
- Package `mdu_pkg` holds:
  - the `e_op` encodings (MD_NONE..MD_MTLO);
  - the `core_op` encodings;
  - the state enum (ST_IDLE, ST_RUN);
  - the counter width constant, sized for max(MUL_CYCLES, DIV_CYCLES).
- The FSM is a single module.
- One natural sub-module, `mdu_lat_counter`:
  - loadable down-counter with load value and load strobe;
  - outputs `last` (`cnt==1`) and `zero`.

## Test plan
- MULT at T=0, MUL_CYCLES=5, `d_uses_md=1` throughout → `core_start` at 0, `busy` 1..5, `hi_we=lo_we=1` at 5 with `hilo_sel=0`, `stall_d` 0..5, `busy=0` at 6.
- DIVU with `e_div_zero=1` → `busy` 1..10, no `hi_we`/`lo_we` at any cycle, idle at 11.
- MTHI then MTLO on consecutive idle cycles → `hi_we` in cycle 0 and `lo_we` in cycle 1, both with `hilo_sel=1`; `busy` never set.
- DIV with `flush=1` on its E cycle → no `core_start`, state IDLE. A MULT with `flush=1` at RUN cycle 3 still commits at cycle 5.
- Reset asserted at cycle 4 of a DIV → IDLE at 5, no write enables at 10, `busy=0`, `proto_err=0`.
- MULT issued, then DIV forced into E at cycle 2 while busy → ignored, `proto_err=1` and held; the MULT commit still occurs at cycle 5.
